river_lane_sched: RTL and testbench

RIVER_LANE_SCHED -- requirements
Module: river_lane_sched

---
 rtl/river_pkg.sv | 19 +
 rtl/pad_step_wrap.sv | 21 ++
 rtl/river_lane_sched.sv | 132 +++++++++++++
 tb/tb_river_lane_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/river_pkg.sv
// Shared types and geometry constants for the river lane scheduler.
package river_pkg;

  // Lane sequencing states: idle, frame wait, pad step, frog resolve.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_STEP    = 2'd2,
    ST_RESOLVE = 2'd3
  } lane_state_t;

  localparam int          COORD_W   = 11;
  localparam logic [10:0] PAD_W     = 11'd40;
  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] STEP      = 11'd10;
  // -40 in 11-bit two's complement: a pad fully off the left edge.
  localparam logic [10:0] WRAP_LEFT = 11'd2008;

endpackage

// File: rtl/pad_step_wrap.sv
// Next X position for one lilypad, including wrap at both screen edges.
module pad_step_wrap
  import river_pkg::*;
(
  input  logic [COORD_W-1:0] i_x,
  input  logic               i_dir,
  output logic [COORD_W-1:0] o_next_x
);

  // Right: a pad at the right edge reappears just off the left edge.
  // Left: a pad fully off the left edge reappears at the right edge.
  always_comb begin
    o_next_x = i_x;
    if (i_dir) begin
      o_next_x = (i_x == SCREEN_W) ? WRAP_LEFT : i_x + STEP;
    end else begin
      o_next_x = (i_x == WRAP_LEFT) ? SCREEN_W : i_x - STEP;
    end
  end

endmodule

// File: rtl/river_lane_sched.sv
// River lane scheduler: steps a row of lilypads every Speed+3 frames and
// reports whether the frog is carried by a pad or has fallen in the water.
module river_lane_sched
  import river_pkg::*;
#(
  parameter int NUM_PADS    = 4,
  parameter int PAD_SPACING = 160
) (
  input  logic                        frame_clk,
  input  logic                        Reset_n,
  input  logic                        Enable,
  input  logic                        Direction,
  input  logic [4:0]                  Speed,
  input  logic [COORD_W-1:0]          Lane_Y,
  input  logic [COORD_W-1:0]          Frog_X,
  input  logic [COORD_W-1:0]          Frog_Y,
  input  logic                        Frog_Hop,
  input  logic                        Clear_Drown,
  output logic [NUM_PADS*COORD_W-1:0] Pad_X,
  output logic                        Step_Strobe,
  output logic                        Carry_Valid,
  output logic [COORD_W-1:0]          Carry_Dx,
  output logic [1:0]                  Carry_Idx,
  output logic                        Drown
);

  lane_state_t        r_state;
  logic [4:0]         r_frameCount;
  logic [COORD_W-1:0] r_pad [NUM_PADS];
  logic [COORD_W-1:0] w_next [NUM_PADS];
  logic [NUM_PADS-1:0] w_hit;
  logic signed [11:0] w_centre;
  logic               w_inLane;
  logic               w_anyHit;
  logic [1:0]         w_hitIdx;
  logic               w_evaluate;

  // Frog centre as a signed 12-bit value so pads straddling the left edge compare correctly.
  assign w_centre   = $signed({1'b0, Frog_X}) + $signed({1'b0, PAD_W >> 1});
  assign w_inLane   = (Frog_Y == Lane_Y);
  assign w_evaluate = Enable && (r_state == ST_RESOLVE) && !Frog_Hop && w_inLane;

  for (genvar g = 0; g < NUM_PADS; g++) begin : gPad
    logic signed [11:0] w_px;

    pad_step_wrap uStep (
      .i_x      (r_pad[g]),
      .i_dir    (Direction),
      .o_next_x (w_next[g])
    );

    assign w_px     = $signed({r_pad[g][COORD_W-1], r_pad[g]});
    assign w_hit[g] = (w_centre >= w_px) && (w_centre < w_px + $signed({1'b0, PAD_W}));
    assign Pad_X[g*COORD_W +: COORD_W] = r_pad[g];
  end

  // Lowest-index pad under the frog wins when pads overlap.
  always_comb begin
    w_anyHit = 1'b0;
    w_hitIdx = 2'd0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_anyHit = 1'b1;
        w_hitIdx = 2'(i);
      end
    end
  end

  // Lane sequencer: frame wait, simultaneous pad step, then carry resolution.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_frameCount <= 5'd0;
      Step_Strobe  <= 1'b0;
      Carry_Valid  <= 1'b0;
      Carry_Dx     <= '0;
      Carry_Idx    <= 2'd0;
      for (int i = 0; i < NUM_PADS; i++) begin
        r_pad[i] <= COORD_W'(i * PAD_SPACING);
      end
    end else begin
      Step_Strobe <= 1'b0;
      Carry_Valid <= 1'b0;
      if (!Enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_WAIT;
            r_frameCount <= 5'd0;
          end
          ST_WAIT: begin
            if (r_frameCount >= Speed) begin
              r_state <= ST_STEP;
            end else begin
              r_frameCount <= r_frameCount + 5'd1;
            end
          end
          ST_STEP: begin
            for (int i = 0; i < NUM_PADS; i++) begin
              r_pad[i] <= w_next[i];
            end
            Step_Strobe <= 1'b1;
            r_state     <= ST_RESOLVE;
          end
          ST_RESOLVE: begin
            if (w_evaluate && w_anyHit) begin
              Carry_Valid <= 1'b1;
              Carry_Idx   <= w_hitIdx;
              Carry_Dx    <= Direction ? STEP : (11'd0 - STEP);
            end
            r_state      <= ST_WAIT;
            r_frameCount <= 5'd0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky drown flag; an explicit clear beats a same-frame drown.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Drown <= 1'b0;
    end else if (Clear_Drown) begin
      Drown <= 1'b0;
    end else if (w_evaluate && !w_anyHit) begin
      Drown <= 1'b1;
    end
  end

endmodule

// File: tb/tb_river_lane_sched.sv
// Directed testbench for river_lane_sched with hand-computed pad positions.
module tb_river_lane_sched;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic        Enable;
  logic        Direction;
  logic [4:0]  Speed;
  logic [10:0] Lane_Y;
  logic [10:0] Frog_X;
  logic [10:0] Frog_Y;
  logic        Frog_Hop;
  logic        Clear_Drown;
  logic [43:0] Pad_X;
  logic        Step_Strobe;
  logic        Carry_Valid;
  logic [10:0] Carry_Dx;
  logic [1:0]  Carry_Idx;
  logic        Drown;

  int totalChecks = 0;
  int badChecks   = 0;

  river_lane_sched #(.NUM_PADS(4), .PAD_SPACING(160)) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .Enable      (Enable),
    .Direction   (Direction),
    .Speed       (Speed),
    .Lane_Y      (Lane_Y),
    .Frog_X      (Frog_X),
    .Frog_Y      (Frog_Y),
    .Frog_Hop    (Frog_Hop),
    .Clear_Drown (Clear_Drown),
    .Pad_X       (Pad_X),
    .Step_Strobe (Step_Strobe),
    .Carry_Valid (Carry_Valid),
    .Carry_Dx    (Carry_Dx),
    .Carry_Idx   (Carry_Idx),
    .Drown       (Drown)
  );

  // Free-running frame clock.
  always #5 frame_clk = ~frame_clk;

  // Absolute time limit in case a step never arrives.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic dir, input logic [4:0] spd,
                               input logic [10:0] fx, input logic [10:0] fy);
    Enable    = en;
    Direction = dir;
    Speed     = spd;
    Frog_X    = fx;
    Frog_Y    = fy;
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic int padAt(input int i);
    return int'(Pad_X[i*11 +: 11]);
  endfunction

  task automatic checkPads(input string tag, input int p0, input int p1, input int p2, input int p3);
    checkOutput({tag, "_pad0"}, padAt(0), p0);
    checkOutput({tag, "_pad1"}, padAt(1), p1);
    checkOutput({tag, "_pad2"}, padAt(2), p2);
    checkOutput({tag, "_pad3"}, padAt(3), p3);
  endtask

  // Returns after the edge that raised Step_Strobe; cycles = edges waited, -1 on timeout.
  task automatic waitStrobe(input int maxCycles, output int cycles);
    bit found;
    found  = 0;
    cycles = -1;
    for (int n = 1; n <= maxCycles && !found; n++) begin
      tick();
      if (Step_Strobe === 1'b1) begin
        found  = 1;
        cycles = n;
      end
    end
    if (!found) checkOutput("strobe_timeout", 0, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkPads(tag, 0, 160, 320, 480);
    checkOutput({tag, "_strobe"}, int'(Step_Strobe), 0);
    checkOutput({tag, "_carry"},  int'(Carry_Valid), 0);
    checkOutput({tag, "_dx"},     int'(Carry_Dx), 0);
    checkOutput({tag, "_idx"},    int'(Carry_Idx), 0);
    checkOutput({tag, "_drown"},  int'(Drown), 0);
  endtask

  initial begin
    int n;
    int strobes;

    Reset_n     = 1'b0;
    Lane_Y      = 11'd100;
    Frog_Hop    = 1'b0;
    Clear_Drown = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd3, 11'd150, 11'd0);
    repeat (2) tick();
    checkResetOutputs("reset");
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    checkOutput("idle_strobe", int'(Step_Strobe), 0);

    // First left step with Speed=3; frog sits where pad1 lands.
    Frog_Y = 11'd100;
    @(negedge frame_clk);
    Enable = 1'b1;
    tick();
    waitStrobe(20, n);
    checkOutput("first_strobe_latency", n, 5);
    checkPads("step1", 2038, 150, 310, 470);
    tick();
    checkOutput("carry_valid", int'(Carry_Valid), 1);
    checkOutput("carry_idx", int'(Carry_Idx), 1);
    checkOutput("carry_dx_left", int'(Carry_Dx), 2038);
    checkOutput("carry_drown", int'(Drown), 0);
    tick();
    checkOutput("carry_pulse_end", int'(Carry_Valid), 0);
    checkOutput("carry_dx_held", int'(Carry_Dx), 2038);
    checkOutput("carry_idx_held", int'(Carry_Idx), 1);

    // Left wrap: pad0 walks 2028, 2018, 2008, then jumps to 640.
    applyStimulus(1'b1, 1'b0, 5'd0, 11'd150, 11'd0);
    waitStrobe(20, n);
    checkOutput("left_2028", padAt(0), 2028);
    waitStrobe(20, n);
    checkOutput("left_2018", padAt(0), 2018);
    waitStrobe(20, n);
    checkOutput("left_2008", padAt(0), 2008);
    waitStrobe(20, n);
    checkPads("left_wrap", 640, 110, 270, 430);

    // Fresh start moving right; pad3 reaches 630 after 15 steps.
    Reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 5'd0, 11'd300, 11'd0);
    tick();
    @(negedge frame_clk);
    Reset_n = 1'b1;
    Enable  = 1'b1;
    for (int s = 0; s < 15; s++) waitStrobe(20, n);
    checkPads("right15", 150, 310, 470, 630);
    waitStrobe(20, n);
    checkOutput("right_640", padAt(3), 640);
    waitStrobe(20, n);
    checkPads("right_wrap", 170, 330, 490, 2008);
    tick();
    checkOutput("out_of_lane_carry", int'(Carry_Valid), 0);
    checkOutput("out_of_lane_drown", int'(Drown), 0);

    // Frog in lane at X=300 with no pad under centre 320.
    Frog_Y = 11'd100;
    waitStrobe(20, n);
    checkPads("step18", 180, 340, 500, 2018);
    tick();
    checkOutput("drown_set", int'(Drown), 1);
    checkOutput("drown_no_carry", int'(Carry_Valid), 0);
    tick();
    tick();
    checkOutput("drown_held", int'(Drown), 1);
    Clear_Drown = 1'b1;
    tick();
    checkOutput("drown_clear_priority", int'(Drown), 0);
    Clear_Drown = 1'b0;
    Frog_Hop    = 1'b1;
    waitStrobe(20, n);
    tick();
    checkOutput("hop_suppresses_drown", int'(Drown), 0);
    Frog_Hop = 1'b0;
    Frog_Y   = 11'd0;

    // Drop Enable mid-wait: pads must freeze and no pulses appear.
    Speed = 5'd10;
    waitStrobe(40, n);
    checkPads("step21", 210, 370, 530, 0);
    repeat (3) tick();
    Enable  = 1'b0;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (Step_Strobe || Carry_Valid) strobes++;
    end
    checkOutput("disabled_pulses", strobes, 0);
    checkPads("frozen", 210, 370, 530, 0);

    // Reset asserted while in STEP: step discarded, outputs back to reset values.
    Speed  = 5'd0;
    Enable = 1'b1;
    tick();
    tick();
    Reset_n = 1'b0;
    #1;
    checkResetOutputs("midstep_reset");
    tick();
    checkOutput("reset_hold_strobe", int'(Step_Strobe), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick();
    checkOutput("post_reset_strobe1", int'(Step_Strobe), 0);
    tick();
    checkOutput("post_reset_strobe2", int'(Step_Strobe), 0);
    checkOutput("post_reset_pad0", padAt(0), 0);
    tick();
    checkOutput("post_reset_first_step", int'(Step_Strobe), 1);
    checkOutput("post_reset_pad1", padAt(1), 170);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
